// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite coordinate fetcher and its neighbours.
// Holds the fetch FSM state type, the default sprite-table placement used by
// the vga block and the software memory map, and the table word-index width.
package sprite_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } fetch_state_e;

  // Default location of the sprite coordinate table in data memory.
  localparam int unsigned SPRITE_BASE_ADDR   = 6000;
  localparam int unsigned SPRITE_ADDR_STRIDE = 4;
  localparam int unsigned SPRITE_NUM_DEFAULT = 3;

  // Bits needed to index the 2*N words of the table (X and Y per sprite).
  function automatic int unsigned word_idx_w(input int unsigned num_sprites);
    return $clog2(2 * num_sprites);
  endfunction

  localparam int unsigned WORD_IDX_W = $clog2(2 * SPRITE_NUM_DEFAULT);

endpackage

// File: rtl/sprite_pos_fetcher_rd_tag_pipe.sv
// rd_tag_pipe: shift register carrying {valid, word index} alongside each
// memory read so the returning data can be steered to its shadow slot.
// Ports: in_vld/in_idx pushed every clock, out_vld/out_idx emerge DEPTH clocks
// later; reset synchronously flushes every stage to invalid.
module rd_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_vld;
    idx_d[0] = in_idx;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/sprite_pos_fetcher.sv
// sprite_pos_fetcher: on each frame_start, reads the 2*NUM_SPRITES word X/Y
// table through the memory read port into shadow registers, then commits all
// coordinates to pos_x/pos_y on a single edge so no sprite tears mid-frame.
// Ports: frame_start in; mem_rd/mem_addr out, mem_data in (READ_LATENCY);
// pos_x/pos_y packed per sprite; busy, frame_done pulse, sticky overrun.
module sprite_pos_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned NUM_SPRITES  = SPRITE_NUM_DEFAULT,
  parameter int unsigned BASE_ADDR    = SPRITE_BASE_ADDR,
  parameter int unsigned ADDR_STRIDE  = SPRITE_ADDR_STRIDE,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  output logic                         mem_rd,
  output logic [WIDTH-1:0]             mem_addr,
  input  logic [WIDTH-1:0]             mem_data,
  output logic [NUM_SPRITES*WIDTH-1:0] pos_x,
  output logic [NUM_SPRITES*WIDTH-1:0] pos_y,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int unsigned NUM_WORDS = 2 * NUM_SPRITES;
  localparam int unsigned IDX_W     = word_idx_w(NUM_SPRITES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [WIDTH-1:0] BASE_W   = WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(ADDR_STRIDE);

  fetch_state_e                 state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         mem_rd_q, mem_rd_d;
  logic [WIDTH-1:0]             mem_addr_q, mem_addr_d;
  logic [NUM_WORDS*WIDTH-1:0]   shadow_q, shadow_d;
  logic [NUM_SPRITES*WIDTH-1:0] pos_x_q, pos_x_d;
  logic [NUM_SPRITES*WIDTH-1:0] pos_y_q, pos_y_d;
  logic                         busy_q, busy_d;
  logic                         frame_done_q, frame_done_d;
  logic                         overrun_q, overrun_d;

  logic                         tag_vld;
  logic [IDX_W-1:0]             tag_idx;

  // Each ISSUE cycle launches one read; its tag leaves the pipe exactly when
  // the matching word is present on mem_data.
  rd_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .IDX_W (IDX_W)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (state_q == ISSUE),
    .in_idx  (idx_q),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    shadow_d     = shadow_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    // Returning read data lands in the shadow slot named by its tag.
    if (tag_vld) begin
      for (int k = 0; k < int'(NUM_WORDS); k++) begin
        if (tag_idx == IDX_W'(k)) begin
          shadow_d[k*WIDTH +: WIDTH] = mem_data;
        end
      end
    end

    // A new frame while any fetch work is outstanding (including the commit
    // cycle itself) is dropped and flagged rather than restarting the walk.
    if (frame_start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = ISSUE;
          idx_d      = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = BASE_W;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          mem_rd_d   = 1'b1;
          // Wraps modulo 2^WIDTH by construction.
          mem_addr_d = mem_addr_q + STRIDE_W;
        end
      end
      DRAIN: begin
        // The last word is written to shadow on this same edge, so COMMIT
        // on the next cycle sees the complete table.
        if (tag_vld && (tag_idx == LAST_IDX)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        for (int i = 0; i < int'(NUM_SPRITES); i++) begin
          pos_x_d[i*WIDTH +: WIDTH] = shadow_q[(2*i)*WIDTH +: WIDTH];
          pos_y_d[i*WIDTH +: WIDTH] = shadow_q[(2*i+1)*WIDTH +: WIDTH];
        end
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= BASE_W;
      shadow_q     <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      shadow_q     <= shadow_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
